// File: rtl/fcc_pkg.sv
// Shared constants and types for the FCC point memory and its consumers.
//   ROWS/COLS       grid dimensions
//   ROW_W/COL_W     row/column index widths
//   LABEL_W         component label width
//   CNT_W           counter width, wide enough for ROWS*COLS
//   cell_t          (row, col, label) stream payload
//   scan_state_e    scanner FSM states
package fcc_pkg;

   localparam int unsigned ROWS    = 30;
   localparam int unsigned COLS    = 30;
   localparam int unsigned ROW_W   = 8;
   localparam int unsigned COL_W   = 5;
   localparam int unsigned LABEL_W = 16;
   localparam int unsigned CNT_W   = $clog2(ROWS*COLS + 1);
   localparam int unsigned CELL_W  = ROW_W + COL_W + LABEL_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } scan_state_e;

   typedef struct packed {
      logic [ROW_W-1:0]   row;
      logic [COL_W-1:0]   col;
      logic [LABEL_W-1:0] label;
   } cell_t;

endpackage

// File: rtl/fcc_skid_fifo.sv
// Two-entry FIFO whose head is always held in a register (entry 0), so the
// read data is a flop output and stays put while no pop occurs.
//   clk, rst_n   clock, async active-low reset
//   push, din    write request and data
//   pop          read request (ignored when empty)
//   dout         head entry
//   full, empty  occupancy flags
//   count        number of stored entries (0..2)
module fcc_skid_fifo #(
   parameter int unsigned DATA_W = 29
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] mem0;
   logic [DATA_W-1:0] mem1;
   logic              do_pop_c;
   logic              do_push_c;

   assign do_pop_c  = pop && (count != 2'd0);
   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_push_c = push && ((count != 2'd2) || do_pop_c);

   assign dout  = mem0;
   assign full  = (count == 2'd2);
   assign empty = (count == 2'd0);

   // Shift-style storage: entry 1 moves to the head on every pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem0  <= '0;
         mem1  <= '0;
         count <= 2'd0;
      end else begin
         unique case ({do_push_c, do_pop_c})
            2'b10: begin
               if (count == 2'd0) mem0 <= din;
               else               mem1 <= din;
               count <= count + 2'd1;
            end
            2'b01: begin
               mem0  <= mem1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  mem0 <= din;
               end else begin
                  mem0 <= mem1;
                  mem1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fcc_label_scanner.sv
// Raster-scans the FCC point memory after labelling and streams every
// labelled, non-ground cell as (row, col, label) with valid/ready handshake.
//   clk, rst_n                       clock, async active-low reset
//   start                            pulse; begins a scan when idle
//   busy, done                       scan in progress / completion pulse
//   rd_row, rd_col                   point memory read address
//   rd_label, rd_is_ground           point memory data, one cycle after address
//   out_valid, out_ready             stream handshake
//   out_row, out_col, out_label      stream payload (FIFO head)
//   emit_count, ground_count         per-scan statistics
module fcc_label_scanner
   import fcc_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [ROW_W-1:0]   rd_row,
   output logic [COL_W-1:0]   rd_col,
   input  logic [LABEL_W-1:0] rd_label,
   input  logic               rd_is_ground,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ROW_W-1:0]   out_row,
   output logic [COL_W-1:0]   out_col,
   output logic [LABEL_W-1:0] out_label,
   output logic [CNT_W-1:0]   emit_count,
   output logic [CNT_W-1:0]   ground_count
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

   scan_state_e      state;
   logic             inflight;
   logic [ROW_W-1:0] iss_row;
   logic [COL_W-1:0] iss_col;

   logic [1:0] fifo_count;
   logic       fifo_full;
   logic       fifo_empty;
   cell_t      fifo_din_c;
   cell_t      fifo_head;

   logic       pop_c;
   logic       push_c;
   logic       ground_hit_c;
   logic [2:0] occ_c;
   logic       issue_c;
   logic       last_addr_c;
   logic       drain_done_c;

   assign pop_c        = out_valid && out_ready;
   assign ground_hit_c = inflight && rd_is_ground;
   assign push_c       = inflight && !rd_is_ground && (rd_label != '0);
   assign fifo_din_c   = '{row: iss_row, col: iss_col, label: rd_label};

   // Occupancy credits the head leaving this cycle, so a continuously ready
   // sink sustains one read per cycle; the total can never exceed two entries.
   assign occ_c        = 3'(fifo_count) - 3'(pop_c) + 3'(inflight);
   assign issue_c      = (state == SCAN) && (occ_c < 3'd2);
   assign last_addr_c  = (rd_row == LAST_ROW) && (rd_col == LAST_COL);
   // Finished once nothing is in flight and the last stored beat is leaving.
   assign drain_done_c = !inflight &&
                         ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop_c));

   assign out_valid = !fifo_empty;
   assign out_row   = fifo_head.row;
   assign out_col   = fifo_head.col;
   assign out_label = fifo_head.label;

   fcc_skid_fifo #(
      .DATA_W (CELL_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_c),
      .din   (fifo_din_c),
      .pop   (pop_c),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // The issue throttle keeps the FIFO from ever being pushed while full.
   assert property (@(posedge clk) disable iff (!rst_n) !(fifo_full && push_c && !pop_c));

   // Scan FSM, address generator and statistics counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         rd_row       <= '0;
         rd_col       <= '0;
         inflight     <= 1'b0;
         iss_row      <= '0;
         iss_col      <= '0;
         emit_count   <= '0;
         ground_count <= '0;
      end else begin
         done     <= 1'b0;
         inflight <= issue_c;
         if (issue_c) begin
            iss_row <= rd_row;
            iss_col <= rd_col;
         end
         if (ground_hit_c && (ground_count != CNT_MAX)) ground_count <= ground_count + CNT_W'(1);
         if (pop_c && (emit_count != CNT_MAX))          emit_count   <= emit_count + CNT_W'(1);

         unique case (state)
            IDLE: begin
               // A start coinciding with the completion pulse is dropped.
               if (start && !done) begin
                  state        <= SCAN;
                  busy         <= 1'b1;
                  rd_row       <= '0;
                  rd_col       <= '0;
                  emit_count   <= '0;
                  ground_count <= '0;
               end
            end
            SCAN: begin
               if (issue_c) begin
                  if (last_addr_c) begin
                     state <= DRAIN;
                  end else if (rd_col == LAST_COL) begin
                     rd_col <= '0;
                     rd_row <= rd_row + ROW_W'(1);
                  end else begin
                     rd_col <= rd_col + COL_W'(1);
                  end
               end
            end
            DRAIN: begin
               if (drain_done_c) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fcc_label_scanner.sv
// Scoreboard bench for fcc_label_scanner: a synchronous-read point memory
// model feeds the scanner, expected beats are queued per scenario and a
// negedge monitor pops and compares every handshake.
module tb_fcc_label_scanner;
   import fcc_pkg::*;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic               busy;
   logic               done;
   logic [ROW_W-1:0]   rd_row;
   logic [COL_W-1:0]   rd_col;
   logic [LABEL_W-1:0] rd_label;
   logic               rd_is_ground;
   logic               out_valid;
   logic               out_ready;
   logic [ROW_W-1:0]   out_row;
   logic [COL_W-1:0]   out_col;
   logic [LABEL_W-1:0] out_label;
   logic [CNT_W-1:0]   emit_count;
   logic [CNT_W-1:0]   ground_count;

   fcc_label_scanner dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .rd_row       (rd_row),
      .rd_col       (rd_col),
      .rd_label     (rd_label),
      .rd_is_ground (rd_is_ground),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_row      (out_row),
      .out_col      (out_col),
      .out_label    (out_label),
      .emit_count   (emit_count),
      .ground_count (ground_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   logic [15:0] lbl [0:ROWS-1][0:COLS-1];
   logic        gnd [0:ROWS-1][0:COLS-1];

   logic [CELL_W-1:0] exp_q [$];
   int beats    = 0;
   int done_cnt = 0;
   int ready_mode = 0;   // 0: always ready, 1: ~30% duty

   task automatic chk(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [CELL_W-1:0] mk(input int r, input int c, input int l);
      return {ROW_W'(r), COL_W'(c), LABEL_W'(l)};
   endfunction

   // Point memory model: one cycle read latency.
   always @(posedge clk) begin
      if (rd_row < ROW_W'(ROWS) && rd_col < COL_W'(COLS)) begin
         rd_label     <= lbl[rd_row][rd_col];
         rd_is_ground <= gnd[rd_row][rd_col];
      end else begin
         rd_label     <= '0;
         rd_is_ground <= 1'b0;
      end
   end

   // Ready driver, changes just after each rising edge.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
      end
   end

   // Monitor: handshake scoreboard plus stall-stability checks.
   logic              stall = 1'b0;
   logic [CELL_W-1:0] stall_data;
   always @(negedge clk) begin
      if (!rst_n) begin
         stall = 1'b0;
      end else begin
         if (stall) begin
            chk("stall_valid", longint'(out_valid), 1);
            chk("stall_payload", longint'({out_row, out_col, out_label}), longint'(stall_data));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", longint'({out_row, out_col, out_label}), 0);
            end else begin
               chk("beat", longint'({out_row, out_col, out_label}), longint'(exp_q.pop_front()));
            end
            beats++;
         end
         if (done) done_cnt++;
         stall      = out_valid && !out_ready;
         stall_data = {out_row, out_col, out_label};
      end
   end

   task automatic fill(input int mode);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            gnd[r][c] = (mode == 0);
            case (mode)
               1:       lbl[r][c] = (r == 3 && c == 7) ? 16'd5 : 16'd0;
               2:       lbl[r][c] = 16'(r*30 + c + 1);
               default: lbl[r][c] = 16'd0;
            endcase
         end
   endtask

   task automatic push_full_raster();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            exp_q.push_back(mk(r, c, r*30 + c + 1));
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_busy"},      longint'(busy), 0);
      chk({tag, "_done"},      longint'(done), 0);
      chk({tag, "_out_valid"}, longint'(out_valid), 0);
      chk({tag, "_rd_addr"},   longint'({rd_row, rd_col}), 0);
      chk({tag, "_counts"},    longint'({emit_count, ground_count}), 0);
      chk({tag, "_payload"},   longint'({out_row, out_col, out_label}), 0);
   endtask

   // Runs one scan: pulse start, wait (bounded) for done, check end state.
   task automatic run_scan(input string tag, input int rmode, input bit extra,
                           input int exp_emit, input int exp_gnd, input int max_lat);
      int  cyc;
      bit  got;
      ready_mode = rmode;
      beats      = 0;
      done_cnt   = 0;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_busy_rise"}, longint'(busy), 1);
      cyc = 0;
      got = 1'b0;
      while (cyc < 5000 && !got) begin
         @(posedge clk); #1;
         cyc++;
         start = extra && (cyc == 10 || cyc == 500);
         if (done) got = 1'b1;
      end
      chk({tag, "_done_seen"}, longint'(got), 1);
      if (max_lat > 0) chk({tag, "_latency_ok"}, longint'(cyc <= max_lat), 1);
      // A start in the done cycle must not launch another scan.
      start = extra;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_busy_after"},   longint'(busy), 0);
      chk({tag, "_done_pulses"},  longint'(done_cnt), 1);
      chk({tag, "_emit_count"},   longint'(emit_count), longint'(exp_emit));
      chk({tag, "_ground_count"}, longint'(ground_count), longint'(exp_gnd));
      chk({tag, "_beats"},        longint'(beats), longint'(exp_emit));
      chk({tag, "_queue_left"},   longint'(exp_q.size()), 0);
   endtask

   initial begin
      int cyc;
      rst_n = 1'b0;
      start = 1'b0;
      fill(0);
      repeat (3) @(posedge clk);
      #1;
      check_idle_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // 1: all ground
      fill(0);
      run_scan("all_ground", 0, 1'b0, 0, 900, 0);

      // 2: single labelled cell
      fill(1);
      exp_q.push_back(mk(3, 7, 5));
      run_scan("single", 0, 1'b0, 1, 0, 0);

      // 3: fully labelled, always ready
      fill(2);
      push_full_raster();
      run_scan("full_ready", 0, 1'b0, 900, 0, 904);

      // 4: fully labelled, sparse ready
      push_full_raster();
      run_scan("full_bp", 1, 1'b0, 900, 0, 0);

      // 5: reset mid-scan, then a fresh full scan
      push_full_raster();
      ready_mode = 0;
      beats = 0;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (beats < 100 && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("abort_reached_100", longint'(beats >= 100), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_zero("abort_in_reset");
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_idle_zero("abort_released");
      push_full_raster();
      run_scan("after_abort", 0, 1'b0, 900, 0, 904);

      // 6: extra starts during the scan and in the done cycle are ignored
      push_full_raster();
      run_scan("extra_start", 0, 1'b1, 900, 0, 904);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
